drop_engine: RTL and testbench
==============================

Name: drop_engine

Overview:
- Downstream stage of the column selector. Consumes its registered 3-bit column code (0 = no key, 1..7 = column) and applies gravity to a 7x6 four-in-a-row board.
- Holds occupancy and ownership for every cell, alternates players, rejects drops into full columns, and can animate the falling token.
- Its board and falling-token outputs drive the LED matrix driver.

Parameters:
- ROWS, 6, board rows; row 0 is the bottom.
- COLS, 7, board columns; column code c maps to column index c-1.
- FALL_DIV, 4, clock cycles the falling token spends on each row. Used only with animation; minimum 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- col  input  3  column code from selector; 0 = idle, 1..7 = column.
- new_game  input  1  synchronous board clear, active-high.
- occ  output  ROWS*COLS  cell occupied; bit index = row*COLS + (c-1).
- owner  output  ROWS*COLS  cell owner (0 = player 0, 1 = player 1); valid only where occ is set.
- player  output  1  player whose turn it is.
- busy  output  1  drop in progress (FALL or PLACE state).
- col_full  output  COLS  column has ROWS tokens.
- board_full  output  1  AND of col_full.
- fall_valid  output  1  falling token visible.
- fall_row  output  3  row of the falling token.
- fall_col  output  3  column code of the falling token.
- drop_done  output  1  one-cycle pulse after a token is written.
- illegal  output  1  one-cycle pulse on a press into a full column.

Behaviour:
- Decided interface: one clock `clk`; reset `rst_n` is synchronous and active-low.
- Reset (rst_n=0 at an edge): every output and internal register goes to 0, state goes to IDLE, and all column heights go to 0.
- new_game=1 at an edge has the same effect as reset but leaves col_q updating. It overrides every other event in that cycle, including an in-flight drop; the drop is aborted and nothing is written.
- Press detection:
  - col_q is col registered each cycle.
  - press = (col != 0) && (col_q == 0). A held key yields exactly one press.
  - A change from one nonzero code to another nonzero code is not a press.
- Per-column height counters, 0..ROWS. col_full[c-1] = (height == ROWS).
- FSM states: IDLE, FALL, PLACE.
- IDLE:
  - Press into a full column: illegal=1 in the next cycle only; stay in IDLE; no other state changes.
  - Press into a non-full column: latch tgt_col = col and tgt_row = height, then go to FALL (animation enabled) or PLACE (animation disabled).
- Presses seen while busy=1 are discarded, not queued.
- FALL:
  - On entry: fall_valid=1, fall_col=tgt_col, fall_row=ROWS-1, divider cleared.
  - Each time the divider reaches FALL_DIV-1 it wraps. If fall_row > tgt_row, fall_row decrements; otherwise go to PLACE.
  - Total FALL duration is (ROWS - tgt_row) * FALL_DIV cycles.
- PLACE (one cycle), at its closing edge:
  - Set occ[tgt_row*COLS+tgt_col-1]=1 and set the matching owner bit to player.
  - Increment height, toggle player, clear fall_valid.
  - Assert drop_done for the next cycle; return to IDLE.
- busy = (state != IDLE).
- Latency with animation disabled: press seen in cycle N, PLACE in cycle N+1, occ updated and drop_done=1 in cycle N+2.
- Board full: every subsequent press produces illegal. board_full stays set until new_game or reset.
- Out-of-range column codes (> COLS, reachable only with COLS < 7) are ignored silently.
- No combinational path from any input to any output.

Optional Feature:
- Macro: DROP_ANIM_EN.
- Defined: FALL state exists and behaves as above. fall_valid, fall_row and fall_col show the falling token.
- Undefined: IDLE goes straight to PLACE. fall_valid, fall_row and fall_col are tied to 0, and FALL_DIV is unused.

Test Plan:
- Reset, then col=3 for 5 cycles, then 0 (animation off) -> occ bit 2 set, owner bit 2 = 0, player=1, and exactly one drop_done, exactly 2 cycles after the press cycle.
- Six separate presses of col=1, then a seventh -> bits 0,7,14,21,28,35 set with owners alternating 0,1,0,1,0,1; col_full[0]=1; seventh press gives one illegal pulse and occ is unchanged.
- Animation on, FALL_DIV=4, empty board, press col=7 -> fall_row steps 5,4,3,2,1,0 with 4 cycles each (24 cycles); busy=1 throughout; then bit 6 set.
- Second key press (col 0->2) during an animated drop -> press ignored; only the first column is written; no illegal pulse.
- new_game asserted mid-fall -> next cycle: occ=0, busy=0, fall_valid=0, player=0, no drop_done.
- Fill all 42 cells -> board_full=1 after the 42nd drop_done; next press gives illegal; new_game clears board_full and col_full.

Source files
------------

// File: rtl/drop_engine.sv
// Gravity and turn engine for a ROWS x COLS four-in-a-row board fed by the column selector.
// Define DROP_ANIM_EN to add the FALL state and drive the fall_valid/fall_row/fall_col token outputs.
module drop_engine #(
   parameter int unsigned ROWS     = 6,
   parameter int unsigned COLS     = 7,
   parameter int unsigned FALL_DIV = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [2:0]           col,
   input  logic                 new_game,
   output logic [ROWS*COLS-1:0] occ,
   output logic [ROWS*COLS-1:0] owner,
   output logic                 player,
   output logic                 busy,
   output logic [COLS-1:0]      col_full,
   output logic                 board_full,
   output logic                 fall_valid,
   output logic [2:0]           fall_row,
   output logic [2:0]           fall_col,
   output logic                 drop_done,
   output logic                 illegal
);
   localparam int unsigned HW     = $clog2(ROWS + 1);
   localparam int unsigned NC     = ROWS * COLS;
   // A zero FALL_DIV is a configuration error; such a build accepts no presses.
   localparam bit          DIV_OK = (FALL_DIV >= 1);

   typedef enum logic [1:0] {IDLE, FALL, PLACE} state_t;
   state_t state, state_d;

   logic [2:0]    col_q;
   logic [2:0]    tgt_col;
   logic [2:0]    tgt_row;
   logic [HW-1:0] height [COLS];
   logic          sel_hit;
   logic          sel_full;
   logic [HW-1:0] sel_height;
   logic          press;
   logic          start;
   logic          place;
   logic          illegal_d;
   logic [NC-1:0] place_mask;

`ifdef DROP_ANIM_EN
   localparam int unsigned DW = (FALL_DIV > 1) ? $clog2(FALL_DIV) : 1;
   logic [DW-1:0] div;
   logic          div_wrap;
   assign div_wrap = (div == DW'(FALL_DIV - 1));
`endif

   always_comb begin
      for (int unsigned c = 0; c < COLS; c++) begin
         col_full[c] = (height[c] == HW'(ROWS));
      end
   end

   assign board_full = &col_full;
   assign busy       = (state != IDLE);

   // Column lookup; codes above COLS never hit, so they are dropped silently.
   always_comb begin
      sel_hit    = 1'b0;
      sel_full   = 1'b0;
      sel_height = '0;
      for (int unsigned c = 0; c < COLS; c++) begin
         if (col == 3'(c + 1)) begin
            sel_hit    = 1'b1;
            sel_full   = col_full[c];
            sel_height = height[c];
         end
      end
   end

   assign press = sel_hit && (col_q == '0) && DIV_OK;

   always_comb begin
      place_mask = '0;
      for (int unsigned r = 0; r < ROWS; r++) begin
         for (int unsigned c = 0; c < COLS; c++) begin
            place_mask[r*COLS + c] = (tgt_row == 3'(r)) && (tgt_col == 3'(c + 1));
         end
      end
   end

   always_comb begin
      state_d   = state;
      start     = 1'b0;
      place     = 1'b0;
      illegal_d = 1'b0;
      case (state)
         IDLE: begin
            if (press) begin
               if (sel_full) begin
                  illegal_d = 1'b1;
               end else begin
                  start = 1'b1;
`ifdef DROP_ANIM_EN
                  state_d = FALL;
`else
                  state_d = PLACE;
`endif
               end
            end
         end
`ifdef DROP_ANIM_EN
         FALL: begin
            if (div_wrap && !(fall_row > tgt_row)) state_d = PLACE;
         end
`endif
         PLACE: begin
            place   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) col_q <= '0;
      else        col_q <= col;
   end

   always_ff @(posedge clk) begin
      if (!rst_n || new_game) state <= IDLE;
      else                    state <= state_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n || new_game) begin
         occ       <= '0;
         owner     <= '0;
         player    <= 1'b0;
         tgt_col   <= '0;
         tgt_row   <= '0;
         drop_done <= 1'b0;
         illegal   <= 1'b0;
         for (int unsigned c = 0; c < COLS; c++) height[c] <= '0;
      end else begin
         drop_done <= place;
         illegal   <= illegal_d;
         if (start) begin
            tgt_col <= col;
            tgt_row <= 3'(sel_height);
         end
         if (place) begin
            occ    <= occ | place_mask;
            owner  <= (owner & ~place_mask) | (place_mask & {NC{player}});
            player <= ~player;
            for (int unsigned c = 0; c < COLS; c++) begin
               if (tgt_col == 3'(c + 1)) height[c] <= height[c] + HW'(1);
            end
         end
      end
   end

`ifdef DROP_ANIM_EN
   always_ff @(posedge clk) begin
      if (!rst_n || new_game) begin
         fall_valid <= 1'b0;
         fall_row   <= '0;
         fall_col   <= '0;
         div        <= '0;
      end else if (start) begin
         fall_valid <= 1'b1;
         fall_row   <= 3'(ROWS - 1);
         fall_col   <= col;
         div        <= '0;
      end else if (state == FALL) begin
         div <= div_wrap ? '0 : div + DW'(1);
         if (div_wrap && (fall_row > tgt_row)) fall_row <= fall_row - 3'd1;
      end else if (place) begin
         fall_valid <= 1'b0;
      end
   end
`else
   assign fall_valid = 1'b0;
   assign fall_row   = '0;
   assign fall_col   = '0;
`endif

endmodule

// File: tb/tb_drop_engine.sv
// Self-checking bench for drop_engine: a per-drop elapsed-time model checked every cycle,
// plus literal expectations for the directed scenarios (builds with or without DROP_ANIM_EN).
module tb_drop_engine;
   localparam int ROWS     = 6;
   localparam int COLS     = 7;
   localparam int FALL_DIV = 4;
   localparam int NC       = ROWS * COLS;
`ifdef DROP_ANIM_EN
   localparam bit ANIM = 1'b1;
`else
   localparam bit ANIM = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          new_game = 1'b0;
   logic [2:0]    col = '0;
   logic [NC-1:0] occ, owner;
   logic          player, busy, board_full, fall_valid, drop_done, illegal;
   logic [COLS-1:0] col_full;
   logic [2:0]    fall_row, fall_col;

   drop_engine #(.ROWS(ROWS), .COLS(COLS), .FALL_DIV(FALL_DIV)) dut (
      .clk(clk), .rst_n(rst_n), .col(col), .new_game(new_game),
      .occ(occ), .owner(owner), .player(player), .busy(busy),
      .col_full(col_full), .board_full(board_full),
      .fall_valid(fall_valid), .fall_row(fall_row), .fall_col(fall_col),
      .drop_done(drop_done), .illegal(illegal)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int n_done = 0, n_ill = 0, n_busy = 0, last_done_cyc = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: board contents plus one in-flight drop tracked by elapsed cycles k.
   bit       m_occ [ROWS][COLS];
   bit       m_own [ROWS][COLS];
   int       m_h [COLS];
   bit       m_player, m_active, m_done, m_ill;
   int       m_k, m_F, m_row, m_col;
   logic [2:0] m_colq;

   function automatic void m_clear();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) begin
            m_occ[r][c] = 1'b0;
            m_own[r][c] = 1'b0;
         end
      for (int c = 0; c < COLS; c++) m_h[c] = 0;
      m_player = 1'b0;
      m_active = 1'b0;
      m_k = 0; m_F = 0; m_row = 0; m_col = 0;
   endfunction

   always @(posedge clk) begin
      cyc++;
      m_done = 1'b0;
      m_ill  = 1'b0;
      if (!rst_n) begin
         m_clear();
         m_colq = '0;
      end else if (new_game) begin
         m_clear();
         m_colq = col;
      end else begin
         if (m_active) begin
            if (m_k == m_F) begin
               m_occ[m_row][m_col-1] = 1'b1;
               m_own[m_row][m_col-1] = m_player;
               m_h[m_col-1]++;
               m_player = !m_player;
               m_active = 1'b0;
               m_done   = 1'b1;
            end else begin
               m_k++;
            end
         end else if (col != 0 && m_colq == 0 && col <= COLS) begin
            if (m_h[col-1] == ROWS) begin
               m_ill = 1'b1;
            end else begin
               m_active = 1'b1;
               m_k   = 0;
               m_row = m_h[col-1];
               m_col = col;
               m_F   = ANIM ? (ROWS - m_row) * FALL_DIV : 0;
            end
         end
         m_colq = col;
      end
   end

   always @(negedge clk) begin
      logic [NC-1:0]   eo, ew;
      logic [COLS-1:0] ef;
      if (chk_en) begin
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
               eo[r*COLS + c] = m_occ[r][c];
               ew[r*COLS + c] = m_own[r][c];
            end
         for (int c = 0; c < COLS; c++) ef[c] = (m_h[c] == ROWS);
         chk("occ", occ, eo);
         chk("owner", owner & eo, ew);
         chk("player", player, m_player);
         chk("busy", busy, m_active);
         chk("col_full", col_full, ef);
         chk("board_full", board_full, &ef);
         chk("drop_done", drop_done, m_done);
         chk("illegal", illegal, m_ill);
         chk("fall_valid", fall_valid, ANIM && m_active);
`ifdef DROP_ANIM_EN
         if (m_active) begin
            chk("fall_row", fall_row, (m_k < m_F) ? (ROWS - 1 - m_k / FALL_DIV) : m_row);
            chk("fall_col", fall_col, m_col);
         end
`else
         chk("fall_row_tied", fall_row, 0);
         chk("fall_col_tied", fall_col, 0);
`endif
      end
      if (drop_done === 1'b1) begin
         n_done++;
         last_done_cyc = cyc;
      end
      if (illegal === 1'b1) n_ill++;
      if (busy === 1'b1) n_busy++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int t = 0;
      while (busy !== 1'b0 && t < 200) begin
         step();
         t++;
      end
      chk("idle_timeout", busy, 0);
   endtask

   task automatic press(input logic [2:0] c, input int hold);
      col = c;
      repeat (hold) step();
      col = '0;
      step();
      wait_idle();
      step();
   endtask

   task automatic do_new_game();
      new_game = 1'b1;
      step();
      new_game = 1'b0;
   endtask

   initial begin
      int n;
      repeat (3) step();
      chk_en = 1'b1;
      chk("rst_occ", occ, 0);
      chk("rst_player", player, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;
      step();

      // Held key yields one drop into column 3, row 0.
      n_done = 0;
      n = cyc;
      col = 3'd3;
      repeat (5) step();
      col = '0;
      step();
      wait_idle();
      step();
      chk("t1_occ", occ, 42'h4);
      chk("t1_owner", owner, 0);
      chk("t1_player", player, 1);
      chk("t1_ndone", n_done, 1);
      chk("t1_latency", last_done_cyc - n, 2 + (ANIM ? ROWS * FALL_DIV : 0));

      // Stack column 1 full, then one more press.
      do_new_game();
      for (int i = 0; i < ROWS; i++) press(3'd1, 1);
      chk("t2_occ", occ, 42'h8_1020_4081);
      chk("t2_owner", owner, 42'h8_0020_0080);
      chk("t2_col_full", col_full, 7'b0000001);
      n_ill = 0;
      press(3'd1, 1);
      chk("t2_illegal", n_ill, 1);
      chk("t2_occ_unchanged", occ, 42'h8_1020_4081);

      // Column 7 on an empty board.
      do_new_game();
      n_busy = 0;
      col = 3'd7;
      step();
      col = '0;
`ifdef DROP_ANIM_EN
      repeat (9) step();
      chk("t3_fall_row_k9", fall_row, 3);
`endif
      wait_idle();
      step();
      chk("t3_busy_cycles", n_busy, ANIM ? ROWS * FALL_DIV + 1 : 1);
      chk("t3_occ", occ, 42'h40);

      // Second key during a drop is discarded.
      do_new_game();
      n_ill = 0;
      n_done = 0;
      col = 3'd4;
      step();
`ifdef DROP_ANIM_EN
      col = '0;
      step();
      step();
      col = 3'd2;
      step();
`else
      col = 3'd2;
      step();
`endif
      col = '0;
      wait_idle();
      repeat (3) step();
      chk("t4_occ", occ, 42'h8);
      chk("t4_illegal", n_ill, 0);
      chk("t4_ndone", n_done, 1);

      // new_game aborts an in-flight drop (player is 1 and occ nonzero here).
      n_done = 0;
      col = 3'd5;
      step();
      col = '0;
`ifdef DROP_ANIM_EN
      repeat (4) step();
`endif
      new_game = 1'b1;
      step();
      new_game = 1'b0;
      chk("t5_occ", occ, 0);
      chk("t5_busy", busy, 0);
      chk("t5_fall_valid", fall_valid, 0);
      chk("t5_player", player, 0);
      repeat (3) step();
      chk("t5_ndone", n_done, 0);

      // Fill the board.
      do_new_game();
      for (int c = 1; c <= COLS; c++)
         for (int r = 0; r < ROWS; r++) press(3'(c), 1);
      chk("t6_board_full", board_full, 1);
      chk("t6_col_full", col_full, 7'h7f);
      chk("t6_occ", occ, 42'h3ff_ffff_ffff);
      n_ill = 0;
      press(3'd3, 1);
      chk("t6_illegal", n_ill, 1);
      do_new_game();
      chk("t6_clear_board_full", board_full, 0);
      chk("t6_clear_col_full", col_full, 0);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "simulation time limit");
   end

endmodule
